// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types: bus word, RAM handshake state and arbiter FSM state.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DGNT  = 2'd1,
        IGNT  = 2'd2,
        RETRY = 2'd3
    } arbstate_t;

endpackage

// File: rtl/memory_arbiter.sv
// Shares the single-port RAM between instruction fetch and the data path.
// Data wins by default; a starvation counter forces fetch through, ERROR is retried.
module memory_arbiter
    import cpu_types_pkg::*;
#(
    parameter int STARVE_MAX = 3
) (
    input  logic      CLK,
    input  logic      nRST,
    input  logic      iREN,
    input  word_t     iaddr,
    output logic      iwait,
    output word_t     iload,
    input  logic      dREN,
    input  logic      dWEN,
    input  word_t     daddr,
    input  word_t     dstore,
    output logic      dwait,
    output word_t     dload,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    input  word_t     ramload,
    input  ramstate_t ramstate,
    output logic [7:0] err_cnt
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    arbstate_t  state, next_state;
    logic       last, next_last;   // 1: RETRY returns to IGNT, 0: to DGNT
    logic [3:0] starve;
    logic       d_done, i_done, err_hit;
    logic       d_req;

    assign d_req = dREN | dWEN;

    always_comb begin
        next_state = state;
        next_last  = last;
        iwait      = 1'b1;
        dwait      = 1'b1;
        iload      = '0;
        dload      = '0;
        ramREN     = 1'b0;
        ramWEN     = 1'b0;
        ramaddr    = '0;
        ramstore   = '0;
        d_done     = 1'b0;
        i_done     = 1'b0;
        err_hit    = 1'b0;
        case (state)
            IDLE: begin
                if (d_req && !(iREN && starve == STARVE_LIM))
                    next_state = DGNT;
                else if (iREN)
                    next_state = IGNT;
            end
            DGNT: begin
                // A withdrawn request drops the enables in the same cycle.
                if (!d_req) begin
                    next_state = IDLE;
                end else begin
                    ramaddr  = daddr;
                    ramstore = dstore;
                    ramWEN   = dWEN;
                    ramREN   = dREN & ~dWEN;
                    case (ramstate)
                        ACCESS: begin
                            dwait      = 1'b0;
                            dload      = ramload;
                            d_done     = 1'b1;
                            next_state = IDLE;
                        end
                        ERROR: begin
                            err_hit    = 1'b1;
                            next_last  = 1'b0;
                            next_state = RETRY;
                        end
                        default: ;
                    endcase
                end
            end
            IGNT: begin
                if (!iREN) begin
                    next_state = IDLE;
                end else begin
                    ramaddr = iaddr;
                    ramREN  = 1'b1;
                    case (ramstate)
                        ACCESS: begin
                            iwait      = 1'b0;
                            iload      = ramload;
                            i_done     = 1'b1;
                            next_state = IDLE;
                        end
                        ERROR: begin
                            err_hit    = 1'b1;
                            next_last  = 1'b1;
                            next_state = RETRY;
                        end
                        default: ;
                    endcase
                end
            end
            RETRY: next_state = last ? IGNT : DGNT;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state   <= IDLE;
            last    <= 1'b0;
            starve  <= '0;
            err_cnt <= '0;
        end else begin
            state <= next_state;
            last  <= next_last;
            if (err_hit && err_cnt != 8'hFF)
                err_cnt <= err_cnt + 8'd1;
            if (!iREN || i_done)
                starve <= '0;
            else if (d_done && starve != STARVE_LIM)
                starve <= starve + 4'd1;
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Randomized bench for memory_arbiter against a transaction-level ownership model.
module tb_memory_arbiter;
    import cpu_types_pkg::*;

    localparam int SM = 3;

    logic       CLK = 1'b0;
    logic       nRST;
    logic       iREN, dREN, dWEN;
    word_t      iaddr, daddr, dstore, ramload;
    logic       iwait, dwait, ramREN, ramWEN;
    word_t      iload, dload, ramaddr, ramstore;
    ramstate_t  ramstate;
    logic [7:0] err_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // model: who owns the RAM (0 nobody, 1 data, 2 instr) and whether a retry gap is pending
    int owner, starve_m, errs_m;
    bit retry_gap, d_done_prev, i_done_prev;
    bit d_on, i_on;

    memory_arbiter #(.STARVE_MAX(SM)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .err_cnt(err_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        owner = 0; retry_gap = 0; starve_m = 0; errs_m = 0;
        d_done_prev = 0; i_done_prev = 0;
    endtask

    task automatic drive();
        bit was_d, was_i;
        int r;
        was_d = d_on;
        was_i = i_on;
        if (d_on && (d_done_prev || $urandom_range(0, 19) == 0)) d_on = 0;
        if (i_on && (i_done_prev || $urandom_range(0, 19) == 0)) i_on = 0;
        if (!was_d && $urandom_range(0, 2) == 0) begin
            d_on = 1;
            r = $urandom_range(0, 2);
            dREN = (r != 1);
            dWEN = (r != 0);
            daddr = $urandom;
            dstore = $urandom;
        end
        if (!d_on) begin dREN = 0; dWEN = 0; end
        if (!was_i && $urandom_range(0, 2) == 0) begin
            i_on = 1;
            iaddr = $urandom;
        end
        iREN = i_on;
        r = $urandom_range(0, 19);
        ramstate = (r < 8) ? ACCESS : (r < 15) ? BUSY : (r < 17) ? FREE : ERROR;
        ramload = $urandom;
    endtask

    // Predict this cycle's outputs from ownership, compare, then advance the model.
    task automatic step_model();
        logic e_iw, e_dw, e_rr, e_rw;
        word_t e_il, e_dl, e_ra, e_rs;
        bit dreq, req, d_done, i_done, active;
        dreq = dREN | dWEN;
        e_iw = 1; e_dw = 1; e_rr = 0; e_rw = 0;
        e_il = 0; e_dl = 0; e_ra = 0; e_rs = 0;
        active = (owner != 0) && !retry_gap;
        req = (owner == 1) ? dreq : iREN;
        d_done = active && owner == 1 && dreq && ramstate == ACCESS;
        i_done = active && owner == 2 && iREN && ramstate == ACCESS;
        if (active && req) begin
            if (owner == 1) begin
                e_ra = daddr; e_rs = dstore;
                e_rw = dWEN; e_rr = dREN && !dWEN;
                if (d_done) begin e_dw = 0; e_dl = ramload; end
            end else begin
                e_ra = iaddr; e_rr = 1;
                if (i_done) begin e_iw = 0; e_il = ramload; end
            end
        end
        chk("iwait", iwait, e_iw);
        chk("dwait", dwait, e_dw);
        chk("iload", iload, e_il);
        chk("dload", dload, e_dl);
        chk("ramREN", ramREN, e_rr);
        chk("ramWEN", ramWEN, e_rw);
        chk("ramaddr", ramaddr, e_ra);
        chk("ramstore", ramstore, e_rs);
        chk("err_cnt", err_cnt, errs_m);

        if (retry_gap) begin
            retry_gap = 0;
        end else if (owner == 0) begin
            if (dreq && !(iREN && starve_m == SM)) owner = 1;
            else if (iREN) owner = 2;
        end else if (!req || ramstate == ACCESS) begin
            owner = 0;
        end else if (ramstate == ERROR) begin
            retry_gap = 1;
            if (errs_m < 255) errs_m++;
        end
        if (!iREN || i_done) starve_m = 0;
        else if (d_done && starve_m < SM) starve_m++;
        d_done_prev = d_done;
        i_done_prev = i_done;
    endtask

    task automatic run_random(input int n);
        for (int c = 0; c < n; c++) begin
            drive();
            #1;
            step_model();
            @(posedge CLK); #1;
        end
    endtask

    initial begin
        int who[8];
        int exp_who[8];
        int k;
        bit found;
        exp_who = '{0, 0, 0, 1, 0, 0, 0, 1};

        nRST = 0; iREN = 1; dREN = 1; dWEN = 0;
        iaddr = 32'h100; daddr = 32'h40; dstore = 32'h5; ramload = 32'hDEADBEEF;
        ramstate = ACCESS;
        d_on = 0; i_on = 0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_iwait", iwait, 1); chk("rst_dwait", dwait, 1);
        chk("rst_iload", iload, 0); chk("rst_dload", dload, 0);
        chk("rst_ramREN", ramREN, 0); chk("rst_ramWEN", ramWEN, 0);
        chk("rst_ramaddr", ramaddr, 0); chk("rst_ramstore", ramstore, 0);
        chk("rst_err_cnt", err_cnt, 0);

        // contention: both held, RAM always ready -> D,D,D,I repeating with bubbles
        nRST = 1; iREN = 1; dREN = 0; dWEN = 1; ramstate = ACCESS;
        k = 0;
        for (int c = 0; c < 16; c++) begin
            #1;
            chk("bubble", ramREN | ramWEN, c % 2);
            if ((ramREN | ramWEN) && k < 8) begin
                who[k] = ramWEN ? 0 : 1;
                k++;
            end
            @(posedge CLK); #1;
        end
        chk("grant_count", k, 8);
        for (int g = 0; g < 8; g++) chk("grant_order", who[g], exp_who[g]);

        iREN = 0; dREN = 0; dWEN = 0; nRST = 0;
        @(posedge CLK); #1;
        nRST = 1;
        model_reset();
        run_random(2500);

        // reset while the data grant is in flight
        found = 0;
        for (int c = 0; c < 300 && !found; c++) begin
            if (owner == 1 && !retry_gap) found = 1;
            else run_random(1);
        end
        chk("find_dgnt", found, 1);
        if (found) begin
            ramstate = BUSY;
            #1;
            chk("pre_rst_en", ramREN | ramWEN, 1);
            nRST = 0;
            #1;
            chk("mid_rst_ramREN", ramREN, 0);
            chk("mid_rst_ramWEN", ramWEN, 0);
            chk("mid_rst_ramaddr", ramaddr, 0);
            chk("mid_rst_dwait", dwait, 1);
            chk("mid_rst_err_cnt", err_cnt, 0);
            @(posedge CLK); #1;
            nRST = 1;
            model_reset();
        end
        run_random(1000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
